// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-locked arbiter sharing one FIFO write port among NUM_REQ producers.
// Optional stall statistics output enabled by defining FIFO_ARB_STATS_EN.
module fifo_wr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4,
  localparam int GW       = $clog2(NUM_REQ),
  localparam int CW       = $clog2(MAX_BURST + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]       req_last,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic                     fifo_full,
  output logic                     fifo_wr_en,
  output logic [WIDTH-1:0]         fifo_wr_data,
  output logic [GW-1:0]            grant_id,
  output logic                     busy
`ifdef FIFO_ARB_STATS_EN
  , output logic [15:0]            stall_cnt
`endif
);

  // Handshake: a beat moves on a cycle where req_valid[g] & req_ready[g];
  // that is exactly the cycle fifo_wr_en is high. Ready never depends on valid.

  typedef enum logic {IDLE, BURST} state_t;

  state_t          state, state_nxt;
  logic [GW-1:0]   grant_nxt;
  logic [GW-1:0]   last_grant, last_grant_nxt;
  logic [GW-1:0]   winner;
  logic [GW-1:0]   idx;
  logic            found;
  logic [CW-1:0]   burst_cnt, burst_cnt_nxt;
  logic [WIDTH-1:0] data_sel;

  // Round-robin search starting just after the previous winner.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = GW'((int'(last_grant) + i) % NUM_REQ);
      if (!found && req_valid[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    data_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id == GW'(i)) data_sel = req_data[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant_id;
    last_grant_nxt = last_grant;
    burst_cnt_nxt  = burst_cnt;
    req_ready      = '0;
    fifo_wr_en     = 1'b0;
    fifo_wr_data   = '0;
    busy           = (state == BURST);
    case (state)
      IDLE: begin
        if (found) begin
          grant_nxt     = winner;
          burst_cnt_nxt = '0;
          state_nxt     = BURST;
        end
      end
      BURST: begin
        req_ready[grant_id] = !fifo_full;
        fifo_wr_en          = req_valid[grant_id] & !fifo_full;
        fifo_wr_data        = data_sel;
        if (fifo_wr_en) begin
          burst_cnt_nxt = burst_cnt + CW'(1);
          if (req_last[grant_id] || burst_cnt == CW'(MAX_BURST - 1)) begin
            state_nxt      = IDLE;
            last_grant_nxt = grant_id;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      grant_id   <= '0;
      last_grant <= GW'(NUM_REQ - 1);
      burst_cnt  <= '0;
    end else begin
      state      <= state_nxt;
      grant_id   <= grant_nxt;
      last_grant <= last_grant_nxt;
      burst_cnt  <= burst_cnt_nxt;
    end
  end

`ifdef FIFO_ARB_STATS_EN
  // Cycles the granted producer had data but the FIFO refused it; saturating.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (state == BURST && req_valid[grant_id] && fifo_full &&
                 stall_cnt != 16'hFFFF) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Round-robin write-side arbiter that shares one synchronous FIFO write port among NUM_REQ producers. Grants are burst-locked: a winner keeps the FIFO port until it marks its last beat or hits MAX_BURST beats. The block sits between producer blocks and the FIFO's wr_en/wr_data/full interface. It applies FIFO backpressure to the granted producer only.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
WIDTH, 8, data width; must match the FIFO data width
MAX_BURST, 4, maximum beats per grant (1..256)

Ports:
clk  in  1  clock
rst  in  1  reset; see Behaviour
req_valid  in  NUM_REQ  per-requester data valid
req_data  in  NUM_REQ*WIDTH  requester i data at bits [i*WIDTH +: WIDTH]
req_last  in  NUM_REQ  per-requester last beat of burst
req_ready  out  NUM_REQ  per-requester beat accepted this cycle when valid&ready
fifo_full  in  1  FIFO full flag
fifo_wr_en  out  1  FIFO write enable
fifo_wr_data  out  WIDTH  FIFO write data
grant_id  out  clog2(NUM_REQ)  current/last granted requester index
busy  out  1  high while in BURST

Behaviour:
- Reset: rst is synchronous and active-high on clock clk.
- Reset values: state=IDLE, grant_id=0, last_grant=NUM_REQ-1 (requester 0 wins first), burst_cnt=0, busy=0. req_ready, fifo_wr_en and fifo_wr_data are all 0.
- State IDLE:
  - All req_ready=0 and fifo_wr_en=0.
  - If any req_valid is high, pick the first valid index searching upward from last_grant+1 with wrap (round-robin).
  - Register grant_id=winner, clear burst_cnt, go to BURST.
  - Arbitration latency: 1 cycle from valid to grant.
- State BURST, with g=grant_id:
  - req_ready[g] = !fifo_full, combinational. All other req_ready=0.
  - fifo_wr_en = req_valid[g] & !fifo_full.
  - fifo_wr_data = req_data[g], combinational passthrough, zero added latency.
  - A beat transfers when fifo_wr_en=1. Each beat increments burst_cnt.
- Exit from BURST: on a transfer with req_last[g]=1 or burst_cnt==MAX_BURST-1. On exit, go to IDLE and set last_grant=g.
  - Every grant therefore costs one IDLE bubble cycle.
- Backpressure: while fifo_full=1, no transfer occurs, burst_cnt holds, and the state holds.
- Producer stall: if req_valid[g]=0 in BURST, the grant is held with no transfer. The grant is never revoked before last or MAX_BURST.
- Requester inputs that are not granted are ignored; their req_ready stays 0.
- req_last on a non-transfer cycle is ignored.
- Reset mid-burst: return to reset state next cycle. Beats already written stay in the FIFO; the rest of the burst is the producer's responsibility.
- grant_id holds its last value in IDLE.

Optional Feature:
- Macro: FIFO_ARB_STATS_EN.
- When defined: adds output stall_cnt (16 bits).
  - Counts cycles in BURST where req_valid[g]=1 and fifo_full=1.
  - Saturates at 16'hFFFF and is cleared by rst.
- When undefined: the port and its counter are absent. All other behaviour is identical.

Test Plan:
- Single requester: req_valid[2]=1 with 3 beats 0xA1,0xA2,0xA3 and last on beat 3 -> grant_id=2 one cycle after valid, 3 consecutive fifo_wr_en pulses carrying A1..A3, then IDLE.
- All 4 requesters continuously valid, last on every beat -> grant order 0,1,2,3,0,1, one beat per grant, IDLE bubble between grants.
- MAX_BURST=4, requester 1 streams 10 beats with no last -> grants of 4 beats, then other requesters if valid, then 4 more, then 2.
- fifo_full asserted for 5 cycles mid-burst -> fifo_wr_en=0 and req_ready[g]=0 during those cycles, burst_cnt unchanged, data resumes without loss or duplication.
- rst pulsed during beat 2 of a 4-beat burst -> next cycle busy=0, req_ready=0, grant_id=0, and requester 0 wins the next arbitration.
- With FIFO_ARB_STATS_EN defined, valid held through 7 full cycles -> stall_cnt=7; rst -> stall_cnt=0.
